copy_job_dispatcher: RTL and testbench
======================================

Name: copy_job_dispatcher

Overview:
- Upstream feeder of the copier engine FSM on the teaching board.
- Debounces the raw start switch and captures the requested copy quantity into a small job FIFO.
- Hands pages one at a time to the engine over a req/ack handshake, pausing while the engine reports a fault (no paper / jam).
- Provides queue and progress status for LEDs/SEG.

Parameters:
- QTY_BITS, 2: width of a job's page count; the value 0 is an empty job.
- DEPTH, 4: job FIFO entries; must be a power of 2, at least 2.
- DEB_CYCLES, 3: consecutive stable-high synchronized samples needed to accept a start press.
- DONE_BITS, 4: width of the completed-jobs counter.

Ports:
- clk_2  input  1  system clock; all state rises on posedge.
- reset  input  1  asynchronous, active-high.
- start_raw  input  1  raw start switch; asynchronous and bouncy.
- qty_in  input  QTY_BITS  page count sampled when the debounced start pulse fires.
- cancel  input  1  synchronous abort of the job in progress.
- fault  input  1  engine in a jam or no-paper state; level signal.
- page_ack  input  1  engine accepted or finished one page; single-cycle pulse.
- page_req  output  1  request one page from the engine.
- pages_left  output  QTY_BITS  pages remaining in the active job.
- busy  output  1  a job is active (state not IDLE).
- q_empty  output  1  FIFO holds 0 jobs.
- q_full  output  1  FIFO holds DEPTH jobs.
- drop  output  1  one-cycle pulse: a job was rejected because the FIFO was full.
- jobs_done  output  DONE_BITS  completed jobs; wraps modulo 2^DONE_BITS.

Behaviour:
- Reset values:
  - page_req=0, pages_left=0, busy=0, drop=0, jobs_done=0.
  - q_empty=1, q_full=0.
  - FIFO pointers and count =0; sync flops =0; debounce counter =0; state IDLE.
- Start synchronization and debounce:
  - start_raw passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized value is 1, saturating at DEB_CYCLES, and clears to 0 whenever the synchronized value is 0.
  - An internal start_pulse is high for exactly one cycle when the counter reaches DEB_CYCLES.
  - A new pulse requires the synchronized input to return to 0 first.
- Enqueue, on start_pulse:
  - qty_in==0: ignored; no write, no drop.
  - FIFO full, including a same-cycle pop: drop=1 for that cycle, no write.
  - Otherwise: write qty_in at wr_ptr; wr_ptr and count advance, wr_ptr wrapping modulo DEPTH.
- Simultaneous push and pop with the FIFO not full: both occur, count unchanged.
- FIFO status: q_empty = (count==0), q_full = (count==DEPTH), both registered-consistent with count.
- Dispatcher FSM states: IDLE, LOAD, REQ, GAP, PAUSE, DONE.
  - IDLE: if !q_empty and !fault, pop the head into pages_left and go to LOAD.
  - LOAD: go to REQ (one bubble cycle, page_req=0).
  - REQ: page_req=1.
    - fault=1 takes priority: page_req=0 in that cycle, go to PAUSE, ack ignored.
    - page_ack=1: pages_left -= 1, go to GAP.
  - GAP: page_req=0. If pages_left==0 go to DONE, else go to REQ.
  - PAUSE: page_req=0; pages_left held. When fault==0, go to REQ.
  - DONE: jobs_done += 1 (wrapping), pages_left=0, go to IDLE.
- page_ack outside REQ is ignored.
- cancel, in any state other than IDLE:
  - next state IDLE, pages_left=0, page_req=0, no jobs_done increment.
  - FIFO contents are untouched.
  - cancel takes priority over page_ack in the same cycle.
- busy = (state != IDLE).
- Latency:
  - From the write edge N, the FSM pops at edge N+1 (LOAD), enters REQ at edge N+2, and page_req is high in the cycle after N+2.
  - From REQ+ack to the next page_req: 2 edges (GAP then REQ).
- Reset asserted mid-job: everything returns to reset values immediately (asynchronous) and queued jobs are lost.

Test Plan:
- Start with qty_in=3, start_raw held high ≥5 cycles, engine acks each req after 1 cycle:
  - exactly 3 page_req/ack pairs, pages_left steps 3→2→1→0.
  - jobs_done=1, then IDLE with q_empty=1.
- start_raw toggles 1,0,1,0 each cycle, then stays high 6 cycles: exactly one job enqueued; none enqueued from the bounces.
- 5 presses with qty=1 and fault held high so nothing dispatches:
  - first 4 enqueue and q_full=1.
  - 5th produces drop=1 for one cycle; count stays 4.
- qty_in=2; assert fault during the first REQ:
  - page_req drops the same cycle and the FSM is in PAUSE with pages_left=2.
  - deassert fault: page_req returns and the job completes with jobs_done=1.
- Cancel during REQ of a qty=3 job while a second job (qty=1) is queued:
  - pages_left=0, no jobs_done increment.
  - the next job starts, ending with jobs_done=1.
- Assert reset while in REQ with 2 jobs queued: page_req=0, q_empty=1, jobs_done=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/copy_job_dispatcher_if.sv
// Bundle of the dispatcher's switch, FIFO-status and engine handshake signals.
// Handshake: page_req is held high by the dispatcher while it wants a page;
// a page is transferred on a rising clk_2 edge where page_req and page_ack are
// both high. page_ack is ignored whenever page_req is low.
interface copy_job_dispatcher_if #(
    parameter int QTY_BITS  = 2,
    parameter int DONE_BITS = 4
);
    logic                 start_raw;
    logic [QTY_BITS-1:0]  qty_in;
    logic                 cancel;
    logic                 fault;
    logic                 page_ack;
    logic                 page_req;
    logic [QTY_BITS-1:0]  pages_left;
    logic                 busy;
    logic                 q_empty;
    logic                 q_full;
    logic                 drop;
    logic [DONE_BITS-1:0] jobs_done;
    logic [2:0]           state_dbg;

    // Dispatcher side
    modport master (
        input  start_raw, qty_in, cancel, fault, page_ack,
        output page_req, pages_left, busy, q_empty, q_full, drop, jobs_done, state_dbg
    );

    // Switch panel / engine side
    modport slave (
        output start_raw, qty_in, cancel, fault, page_ack,
        input  page_req, pages_left, busy, q_empty, q_full, drop, jobs_done, state_dbg
    );
endinterface

// File: rtl/copy_job_dispatcher.sv
// Copy job dispatcher: debounces the start switch, queues page counts in a
// small FIFO and feeds pages one at a time to the copier engine.
// state_dbg encoding: IDLE=0 LOAD=1 REQ=2 GAP=3 PAUSE=4 DONE=5.
module copy_job_dispatcher #(
    parameter int QTY_BITS   = 2,
    parameter int DEPTH      = 4,
    parameter int DEB_CYCLES = 3,
    parameter int DONE_BITS  = 4
) (
    input  logic                         clk_2,
    input  logic                         reset,
    copy_job_dispatcher_if.master        bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        REQ   = 3'd2,
        GAP   = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;

    logic                 sync1, sync2;
    logic [DW-1:0]        deb_cnt;
    logic                 start_pulse;
    logic [QTY_BITS-1:0]  mem [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 q_empty_w, q_full_w;
    logic                 push_req, push, pop;
    state_t               state, state_n;
    logic [QTY_BITS-1:0]  pages_left_r, pages_left_n;
    logic [DONE_BITS-1:0] jobs_done_r;
    logic                 done_inc;
    logic                 req;

    // Two-flop synchronizer for the asynchronous start switch
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.start_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: count stable-high samples, saturate, pulse once on reaching the threshold
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            deb_cnt     <= '0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= sync2 && (deb_cnt == DW'(DEB_CYCLES - 1));
            if (!sync2)
                deb_cnt <= '0;
            else if (deb_cnt != DW'(DEB_CYCLES))
                deb_cnt <= deb_cnt + DW'(1);
        end
    end

    assign q_empty_w = (count == '0);
    assign q_full_w  = (count == CW'(DEPTH));
    assign push_req  = start_pulse && (bus.qty_in != '0);
    // A full FIFO rejects the job even if the head is popped in the same cycle
    assign push      = push_req && !q_full_w;

    // Job FIFO storage (no reset needed; validity is tracked by count)
    always_ff @(posedge clk_2) begin
        if (push)
            mem[wr_ptr] <= bus.qty_in;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Dispatcher state, page counter and completed-job counter
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pages_left_r <= '0;
            jobs_done_r  <= '0;
        end else begin
            state        <= state_n;
            pages_left_r <= pages_left_n;
            if (done_inc)
                jobs_done_r <= jobs_done_r + DONE_BITS'(1);
        end
    end

    // Next-state, pop and page request; fault outranks ack, cancel outranks everything
    always_comb begin
        state_n      = state;
        pages_left_n = pages_left_r;
        done_inc     = 1'b0;
        pop          = 1'b0;
        req          = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty_w && !bus.fault) begin
                    pop          = 1'b1;
                    pages_left_n = mem[rd_ptr];
                    state_n      = LOAD;
                end
            end
            LOAD: state_n = REQ;
            REQ: begin
                if (bus.fault) begin
                    state_n = PAUSE;
                end else begin
                    req = 1'b1;
                    if (bus.page_ack) begin
                        pages_left_n = pages_left_r - QTY_BITS'(1);
                        state_n      = GAP;
                    end
                end
            end
            GAP:   state_n = (pages_left_r == '0) ? DONE : REQ;
            PAUSE: if (!bus.fault) state_n = REQ;
            DONE: begin
                done_inc     = 1'b1;
                pages_left_n = '0;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (bus.cancel && (state != IDLE)) begin
            state_n      = IDLE;
            pages_left_n = '0;
            req          = 1'b0;
            done_inc     = 1'b0;
        end
    end

    assign bus.page_req   = req;
    assign bus.pages_left = pages_left_r;
    assign bus.busy       = (state != IDLE);
    assign bus.q_empty    = q_empty_w;
    assign bus.q_full     = q_full_w;
    assign bus.drop       = push_req && q_full_w;
    assign bus.jobs_done  = jobs_done_r;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_copy_job_dispatcher.sv
// Bench for copy_job_dispatcher: switch-press driver, auto-acking engine model,
// page scoreboard, press table and hand-written fault/cancel/reset sequences.
module tb_copy_job_dispatcher;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd4;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;

    copy_job_dispatcher_if #(.QTY_BITS(2), .DONE_BITS(4)) bus ();

    copy_job_dispatcher #(
        .QTY_BITS(2), .DEPTH(4), .DEB_CYCLES(3), .DONE_BITS(4)
    ) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk_2 = ~clk_2;

    int         checks   = 0;
    int         errors   = 0;
    int         drop_cnt = 0;
    int         ack_cnt  = 0;
    logic [1:0] exp_q[$];
    bit         auto_ack = 1'b0;
    bit         req_seen = 1'b0;

    typedef struct {
        logic [1:0] qty;
        int         hi;
        bit         enq;
        bit         drp;
        bit         empty;
        bit         full;
    } row_t;
    row_t tbl[8];

    // Engine model: acks a request one cycle after first seeing it
    always @(posedge clk_2) begin
        #1;
        if (auto_ack && bus.page_req && req_seen)
            bus.page_ack = 1'b1;
        else
            bus.page_ack = 1'b0;
        req_seen = bus.page_req && !bus.page_ack;
    end

    // Monitor: drop pulses and accepted pages against the scoreboard
    always @(negedge clk_2) begin
        logic [1:0] e;
        if (bus.drop) drop_cnt++;
        if (!reset && bus.page_req && bus.page_ack) begin
            ack_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_page pages_left=%0d expected none", bus.pages_left);
            end else begin
                e = exp_q.pop_front();
                if (bus.pages_left !== e) begin
                    errors++;
                    $display("FAIL sb_page got=%0d exp=%0d", bus.pages_left, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic push_job(input logic [1:0] q);
        for (int p = int'(q); p >= 1; p--) exp_q.push_back(2'(p));
    endtask

    task automatic press(input logic [1:0] q, input int hi);
        bus.qty_in    = q;
        bus.start_raw = 1'b1;
        repeat (hi) step();
        bus.start_raw = 1'b0;
        repeat (5) step();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk_2);
        while ((bus.busy || !bus.q_empty) && n < 300) begin
            @(negedge clk_2);
            n++;
        end
        check({name, "_timeout"}, (n >= 300), 0);
        step();
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        @(negedge clk_2);
        while (!bus.page_req && n < 100) begin
            @(negedge clk_2);
            n++;
        end
        check({name, "_timeout"}, (n >= 100), 0);
    endtask

    initial begin
        int d0, a0, n;
        tbl[0] = '{2'd0, 6, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{2'd1, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{2'd1, 3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2'd2, 6, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'd3, 4, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{2'd1, 5, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{2'd2, 5, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{2'd0, 5, 1'b0, 1'b0, 1'b0, 1'b1};

        bus.start_raw = 1'b0;
        bus.qty_in    = '0;
        bus.cancel    = 1'b0;
        bus.fault     = 1'b0;
        bus.page_ack  = 1'b0;
        repeat (3) @(posedge clk_2);
        #1 reset = 1'b0;
        @(negedge clk_2);
        check("rst_page_req", bus.page_req, 0);
        check("rst_pages_left", bus.pages_left, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_drop", bus.drop, 0);
        check("rst_jobs_done", bus.jobs_done, 0);
        check("rst_q_empty", bus.q_empty, 1);
        check("rst_q_full", bus.q_full, 0);
        step();

        // Single qty=3 job with latency check from the FIFO write
        auto_ack = 1'b1;
        a0 = ack_cnt;
        push_job(2'd3);
        bus.qty_in    = 2'd3;
        bus.start_raw = 1'b1;
        n = 0;
        @(negedge clk_2);
        while (bus.q_empty && n < 20) begin
            @(negedge clk_2);
            n++;
        end
        check("lat_write_timeout", (n >= 20), 0);
        check("lat_idle_state", bus.state_dbg, S_IDLE);
        @(negedge clk_2);
        check("lat_load_state", bus.state_dbg, S_LOAD);
        check("lat_load_req", bus.page_req, 0);
        check("lat_load_busy", bus.busy, 1);
        @(negedge clk_2);
        check("lat_req_high", bus.page_req, 1);
        check("lat_req_pages", bus.pages_left, 3);
        step();
        bus.start_raw = 1'b0;
        wait_idle("job3");
        check("job3_acks", ack_cnt - a0, 3);
        check("job3_done", bus.jobs_done, 1);
        check("job3_pages_left", bus.pages_left, 0);
        check("job3_q_empty", bus.q_empty, 1);

        // Bouncing switch: single-cycle highs never count, the final hold does
        a0 = ack_cnt;
        push_job(2'd1);
        bus.qty_in = 2'd1;
        for (int i = 0; i < 4; i++) begin
            bus.start_raw = (i % 2 == 0);
            step();
        end
        press(2'd1, 6);
        wait_idle("bounce");
        repeat (10) step();
        check("bounce_acks", ack_cnt - a0, 1);
        check("bounce_done", bus.jobs_done, 2);

        // Press table with fault held so nothing dispatches
        bus.fault = 1'b1;
        a0 = ack_cnt;
        for (int r = 0; r < 8; r++) begin
            d0 = drop_cnt;
            if (tbl[r].enq) push_job(tbl[r].qty);
            press(tbl[r].qty, tbl[r].hi);
            check($sformatf("tbl%0d_drop", r), drop_cnt - d0, {31'd0, tbl[r].drp});
            check($sformatf("tbl%0d_q_empty", r), bus.q_empty, {31'd0, tbl[r].empty});
            check($sformatf("tbl%0d_q_full", r), bus.q_full, {31'd0, tbl[r].full});
            check($sformatf("tbl%0d_busy", r), bus.busy, 0);
        end
        bus.fault = 1'b0;
        wait_idle("tbl_drain");
        check("tbl_acks", ack_cnt - a0, 7);
        check("tbl_done", bus.jobs_done, 6);

        // Fault during the first REQ of a qty=2 job
        auto_ack = 1'b0;
        push_job(2'd2);
        press(2'd2, 4);
        wait_req("fault_req");
        check("fault_pre_pages", bus.pages_left, 2);
        bus.fault = 1'b1;
        #1;
        check("fault_req_drop", bus.page_req, 0);
        @(negedge clk_2);
        check("fault_pause_state", bus.state_dbg, S_PAUSE);
        check("fault_pause_pages", bus.pages_left, 2);
        repeat (3) @(negedge clk_2);
        check("fault_hold_state", bus.state_dbg, S_PAUSE);
        check("fault_hold_pages", bus.pages_left, 2);
        check("fault_hold_req", bus.page_req, 0);
        step();
        bus.fault = 1'b0;
        auto_ack  = 1'b1;
        wait_idle("fault_job");
        check("fault_done", bus.jobs_done, 7);

        // Cancel during REQ of a qty=3 job with a qty=1 job queued behind it
        auto_ack  = 1'b0;
        bus.fault = 1'b1;
        press(2'd3, 4);
        push_job(2'd1);
        press(2'd1, 4);
        bus.fault = 1'b0;
        wait_req("cancel_req");
        check("cancel_pre_pages", bus.pages_left, 3);
        bus.cancel = 1'b1;
        #1;
        check("cancel_req_low", bus.page_req, 0);
        step();
        bus.cancel = 1'b0;
        @(negedge clk_2);
        check("cancel_pages_left", bus.pages_left, 0);
        check("cancel_no_done", bus.jobs_done, 7);
        check("cancel_queue_kept", bus.q_empty, 0);
        step();
        auto_ack = 1'b1;
        wait_idle("cancel_next");
        check("cancel_next_done", bus.jobs_done, 8);

        // Asynchronous reset in REQ with two jobs still queued
        auto_ack  = 1'b0;
        bus.fault = 1'b1;
        press(2'd2, 4);
        press(2'd3, 4);
        press(2'd1, 4);
        bus.fault = 1'b0;
        wait_req("reset_req");
        check("reset_pre_q_empty", bus.q_empty, 0);
        reset = 1'b1;
        #1;
        check("reset_page_req", bus.page_req, 0);
        check("reset_q_empty", bus.q_empty, 1);
        check("reset_jobs_done", bus.jobs_done, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_pages_left", bus.pages_left, 0);
        step();
        reset = 1'b0;
        repeat (4) step();
        check("post_reset_busy", bus.busy, 0);
        check("post_reset_q_empty", bus.q_empty, 1);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
